// File: rtl/fb_pkg.sv
// Shared types and constants for the triple-buffer frame arbiter.
// No logic of its own; no latency; no backpressure.
// Holds the index type, the default DDR bases, the FSM encoding and the spare-index helper.
package fb_pkg;

    typedef logic [1:0] fb_idx_t;

    localparam logic [31:0] FB_BASE0_DEF = 32'h0100_0000;
    localparam logic [31:0] FB_BASE1_DEF = 32'h0110_0000;
    localparam logic [31:0] FB_BASE2_DEF = 32'h0120_0000;

    localparam fb_idx_t W_IDX_RST   = 2'd0;
    localparam fb_idx_t R_IDX_RST   = 2'd1;
    localparam fb_idx_t RDY_IDX_RST = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fb_state_t;

    // With a and b distinct in 0..2, 3-a-b (mod 4) is the remaining buffer.
    function automatic fb_idx_t fb_third_idx(input fb_idx_t a, input fb_idx_t b);
        return fb_idx_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/frame_buffer_arbiter_rise_detect.sv
// One-bit rising-edge detector with a registered history bit.
// Zero latency: the pulse is asserted for the cycle that first samples i_d high; no backpressure.
// The history bit keeps updating continuously, so a long high level yields only one pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Triple-buffer arbiter that hands DDR frame-buffer bases to an AXI writer and an AXI reader.
// One-cycle latency: state, indices and counters update on the edge that first sees an event.
// No backpressure: events arriving in IDLE are dropped; the statistics counters saturate.
module frame_buffer_arbiter #(
    parameter logic [31:0] BASE0 = fb_pkg::FB_BASE0_DEF,
    parameter logic [31:0] BASE1 = fb_pkg::FB_BASE1_DEF,
    parameter logic [31:0] BASE2 = fb_pkg::FB_BASE2_DEF,
    parameter int          CNT_W = 16
) (
    input  logic             clk_100Mhz,
    input  logic             sys_rst_n,
    input  logic             enable,
    input  logic             writer_done,
    input  logic             vsync_sync2,
    output logic [31:0]      w_base_addr,
    output logic [31:0]      r_base_addr,
    output logic [1:0]       w_idx,
    output logic [1:0]       r_idx,
    output logic             r_valid,
    output logic [CNT_W-1:0] frames_written,
    output logic [CNT_W-1:0] frames_dropped,
    output logic [CNT_W-1:0] frames_repeated
);

    import fb_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fb_state_t        r_state;
    fb_state_t        w_state_nxt;
    logic             w_run_act;
    logic             w_clear;

    logic             w_done_rise;
    logic             w_vs_rise;

    fb_idx_t          r_wr_idx;
    fb_idx_t          r_rd_idx;
    fb_idx_t          r_rdy_idx;
    logic             r_rdy_valid;
    logic             r_rd_valid;

    logic             w_inc_written;
    logic             w_inc_dropped;
    logic             w_inc_repeated;

    logic [CNT_W-1:0] r_cnt_written;
    logic [CNT_W-1:0] r_cnt_dropped;
    logic [CNT_W-1:0] r_cnt_repeated;

    rise_detect u_done_rise (
        .clk    (clk_100Mhz),
        .rst_n  (sys_rst_n),
        .i_d    (writer_done),
        .o_rise (w_done_rise)
    );

    rise_detect u_vsync_rise (
        .clk    (clk_100Mhz),
        .rst_n  (sys_rst_n),
        .i_d    (vsync_sync2),
        .o_rise (w_vs_rise)
    );

    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Edges are only honoured while RUN is held; the leaving edge restores the buffer map.
    always_comb begin
        w_run_act = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_run_act = enable;
                w_clear   = ~enable;
            end
            default: begin
                w_run_act = 1'b0;
                w_clear   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_inc_written  = 1'b0;
        w_inc_dropped  = 1'b0;
        w_inc_repeated = 1'b0;
        if (w_run_act) begin
            w_inc_written  = w_done_rise;
            w_inc_dropped  = w_done_rise & r_rdy_valid;
            w_inc_repeated = w_vs_rise & ~w_done_rise & ~r_rdy_valid;
        end
    end

    // Swaps keep {writer, reader, ready} a permutation of 0..2 at all times.
    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_idx    <= W_IDX_RST;
            r_rd_idx    <= R_IDX_RST;
            r_rdy_idx   <= RDY_IDX_RST;
            r_rdy_valid <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else if (w_clear) begin
            r_wr_idx    <= W_IDX_RST;
            r_rd_idx    <= R_IDX_RST;
            r_rdy_idx   <= RDY_IDX_RST;
            r_rdy_valid <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else if (w_run_act) begin
            case ({w_done_rise, w_vs_rise})
                2'b10: begin
                    r_rdy_idx   <= r_wr_idx;
                    r_rdy_valid <= 1'b1;
                    r_wr_idx    <= fb_third_idx(r_wr_idx, r_rd_idx);
                end
                2'b01: begin
                    if (r_rdy_valid) begin
                        r_rd_idx    <= r_rdy_idx;
                        r_rdy_idx   <= r_rd_idx;
                        r_rdy_valid <= 1'b0;
                        r_rd_valid  <= 1'b1;
                    end
                end
                2'b11: begin
                    r_rd_idx    <= r_wr_idx;
                    r_wr_idx    <= fb_third_idx(r_wr_idx, r_rd_idx);
                    r_rdy_idx   <= r_rd_idx;
                    r_rdy_valid <= 1'b0;
                    r_rd_valid  <= 1'b1;
                end
                default: begin
                    r_rdy_valid <= r_rdy_valid;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_written  <= '0;
            r_cnt_dropped  <= '0;
            r_cnt_repeated <= '0;
        end else begin
            if (w_inc_written && r_cnt_written != CNT_MAX) begin
                r_cnt_written <= r_cnt_written + 1'b1;
            end
            if (w_inc_dropped && r_cnt_dropped != CNT_MAX) begin
                r_cnt_dropped <= r_cnt_dropped + 1'b1;
            end
            if (w_inc_repeated && r_cnt_repeated != CNT_MAX) begin
                r_cnt_repeated <= r_cnt_repeated + 1'b1;
            end
        end
    end

    function automatic logic [31:0] base_of(input fb_idx_t idx);
        case (idx)
            2'd0:    return BASE0;
            2'd1:    return BASE1;
            2'd2:    return BASE2;
            default: return BASE0;
        endcase
    endfunction

    assign w_base_addr     = base_of(r_wr_idx);
    assign r_base_addr     = base_of(r_rd_idx);
    assign w_idx           = r_wr_idx;
    assign r_idx           = r_rd_idx;
    assign r_valid         = r_rd_valid;
    assign frames_written  = r_cnt_written;
    assign frames_dropped  = r_cnt_dropped;
    assign frames_repeated = r_cnt_repeated;

endmodule
